// File: rtl/pixel_xform_stream.sv
// Per-sample pixel transform (pass/brighten/darken/invert/threshold) with a valid/ready
// output FIFO. Optional stats counters are enabled by defining PIXEL_XFORM_STATS_EN.
module pixel_xform_stream #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DEF_OFFSET = 50,
    parameter int unsigned ALT_OFFSET = 75
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic [2:0]        mode,
    input  logic              offset_sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sat_flag,
    output logic [15:0]       pix_count,
    output logic [15:0]       sat_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned EXT_W = DATA_W + 1;
    localparam logic [EXT_W-1:0]  MAX_EXT = {1'b0, {DATA_W{1'b1}}};
    localparam logic [DATA_W-1:0] MAX_VAL = {DATA_W{1'b1}};
    localparam logic [EXT_W-1:0]  DEF_K   = EXT_W'(DEF_OFFSET);
    localparam logic [EXT_W-1:0]  ALT_K   = EXT_W'(ALT_OFFSET);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Each entry holds {sat, data}
    logic [EXT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic              accept;
    logic              pop;
    logic [CNT_W-1:0]  count_nxt;
    logic [CNT_W-1:0]  remain;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [EXT_W-1:0]  x_ext;
    logic [EXT_W-1:0]  k_ext;
    logic [EXT_W-1:0]  sum_ext;
    logic [DATA_W-1:0] y;
    logic              sat;
    logic [DATA_W-1:0] head_data_nxt;
    logic              head_sat_nxt;

    // Transform of the sample presented this cycle
    always_comb begin
        x_ext   = {1'b0, in_data};
        k_ext   = offset_sel ? ALT_K : DEF_K;
        sum_ext = x_ext + k_ext;
        y       = in_data;
        sat     = 1'b0;
        case (mode)
            3'b001: begin
                if (sum_ext > MAX_EXT) begin
                    y   = MAX_VAL;
                    sat = 1'b1;
                end else begin
                    y = sum_ext[DATA_W-1:0];
                end
            end
            3'b010: begin
                if (x_ext >= k_ext) begin
                    y = DATA_W'(x_ext - k_ext);
                end else begin
                    y   = '0;
                    sat = 1'b1;
                end
            end
            3'b011:  y = MAX_VAL - in_data;
            3'b100:  y = (x_ext >= k_ext) ? MAX_VAL : '0;
            default: y = in_data;
        endcase
    end

    // FIFO bookkeeping and next head selection
    always_comb begin
        accept        = in_valid && in_ready;
        pop           = out_valid && out_ready;
        count_nxt     = count + CNT_W'(accept) - CNT_W'(pop);
        remain        = count - CNT_W'(pop);
        rd_ptr_nxt    = rd_ptr + PTR_W'(pop);
        head_data_nxt = out_data;
        head_sat_nxt  = sat_flag;
        if (remain != '0) begin
            {head_sat_nxt, head_data_nxt} = mem[rd_ptr_nxt];
        end else if (accept) begin
            head_sat_nxt  = sat;
            head_data_nxt = y;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= {sat, y};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            in_ready  <= (count_nxt < DEPTH_C);
            out_valid <= (count_nxt != '0);
            out_data  <= head_data_nxt;
            sat_flag  <= head_sat_nxt;
        end
    end

`ifdef PIXEL_XFORM_STATS_EN
    // Saturating accept / clip counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_count <= '0;
            sat_count <= '0;
        end else if (accept) begin
            if (pix_count != 16'hFFFF) begin
                pix_count <= pix_count + 16'd1;
            end
            if (sat && (sat_count != 16'hFFFF)) begin
                sat_count <= sat_count + 16'd1;
            end
        end
    end
`else
    assign pix_count = '0;
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_pixel_xform_stream.sv
// Bench for pixel_xform_stream: directed and random traffic checked against a
// queue-based reference model of the transform and the output buffer.
module tb_pixel_xform_stream;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [2:0]  mode;
    logic        offset_sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        sat_flag;
    logic [15:0] pix_count;
    logic [15:0] sat_count;

    pixel_xform_stream dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mode       (mode),
        .offset_sel (offset_sel),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .sat_flag   (sat_flag),
        .pix_count  (pix_count),
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] q[$];          // expected {sat, data} in acceptance order
    int         mpix = 0;
    int         msat = 0;
    bit         post_reset = 0;
    logic       acc;

    // Reference transform from plain integer arithmetic
    function automatic logic [8:0] ref_xf(input int x, input int m, input int sel);
        int k;
        k = sel ? 75 : 50;
        case (m)
            1: return (x + k > 255) ? {1'b1, 8'd255} : {1'b0, 8'(x + k)};
            2: return (x < k) ? {1'b1, 8'd0} : {1'b0, 8'(x - k)};
            3: return {1'b0, 8'(255 - x)};
            4: return {1'b0, (x >= k) ? 8'd255 : 8'd0};
            default: return {1'b0, 8'(x)};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(q[0][7:0]));
            chk("sat_flag", 32'(sat_flag), 32'(q[0][8]));
        end else if (post_reset) begin
            chk("out_data_rst", 32'(out_data), 32'd0);
            chk("sat_flag_rst", 32'(sat_flag), 32'd0);
        end
`ifdef PIXEL_XFORM_STATS_EN
        chk("pix_count", 32'(pix_count), 32'(mpix));
        chk("sat_count", 32'(sat_count), 32'(msat));
`else
        chk("pix_count", 32'(pix_count), 32'd0);
        chk("sat_count", 32'(sat_count), 32'd0);
`endif
    endtask

    // One clock: check state, drive inputs, advance the model at the edge
    task automatic step(input logic v, input logic [7:0] d, input logic [2:0] m,
                        input logic s, input logic r, output logic a);
        bit do_pop;
        @(negedge clk);
        check_outputs();
        reset_n    = 1'b1;
        in_valid   = v;
        in_data    = d;
        mode       = m;
        offset_sel = s;
        out_ready  = r;
        @(posedge clk);
        a      = v && (q.size() < DEPTH);
        do_pop = (q.size() != 0) && r;
        if (do_pop) void'(q.pop_front());
        if (a) begin
            logic [8:0] e;
            e = ref_xf(int'(d), int'(m), int'(s));
            q.push_back(e);
            post_reset = 0;
            if (mpix < 16'hFFFF) mpix++;
            if (e[8] && msat < 16'hFFFF) msat++;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] m, input logic s, input logic r);
        logic a;
        int   n;
        a = 1'b0;
        n = 0;
        while (!a && n < 50) begin
            step(1'b1, d, m, s, r, a);
            n++;
        end
        chk("accept_timeout", 32'(a), 32'd1);
    endtask

    task automatic idle(input int n, input logic r);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 3'd0, 1'b0, r, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        q.delete();
        mpix       = 0;
        msat       = 0;
        post_reset = 1;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0; offset_sel = 1'b0; out_ready = 1'b1;
        do_reset();
        // Reset then idle
        idle(3, 1'b1);

        // Brighten with default offset, one sample per cycle
        send(8'd10, 3'b001, 1'b0, 1'b1);
        send(8'd200, 3'b001, 1'b0, 1'b1);
        send(8'd205, 3'b001, 1'b0, 1'b1);
        send(8'd255, 3'b001, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Darken with alternate offset
        send(8'd100, 3'b010, 1'b1, 1'b1);
        send(8'd75, 3'b010, 1'b1, 1'b1);
        send(8'd30, 3'b010, 1'b1, 1'b1);
        send(8'd0, 3'b010, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Back-pressure: fill, stall, then drain
        for (int i = 0; i < 4; i++) send(8'(20 * i + 7), 3'b000, 1'b0, 1'b0);
        step(1'b1, 8'd99, 3'b000, 1'b0, 1'b0, acc);
        step(1'b1, 8'd99, 3'b000, 1'b0, 1'b0, acc);
        send(8'd99, 3'b000, 1'b0, 1'b1);
        send(8'd123, 3'b000, 1'b0, 1'b1);
        idle(6, 1'b1);

        // Invert/threshold alternating; mode changes while full must not touch the buffer
        send(8'd0, 3'b011, 1'b0, 1'b0);
        send(8'd49, 3'b100, 1'b0, 1'b0);
        send(8'd50, 3'b011, 1'b0, 1'b0);
        send(8'd255, 3'b100, 1'b0, 1'b0);
        step(1'b0, 8'd0, 3'b001, 1'b1, 1'b0, acc);
        step(1'b0, 8'd0, 3'b010, 1'b0, 1'b0, acc);
        idle(6, 1'b1);

        // Reset with samples buffered
        for (int i = 0; i < 3; i++) send(8'(i + 1), 3'b001, 1'b0, 1'b0);
        do_reset();
        idle(1, 1'b1);
        send(8'd42, 3'b000, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Random traffic including unused modes
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), acc);
        end
        idle(8, 1'b1);
        @(negedge clk);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
